ubus_ctrl: RTL and testbench
============================

// Module: ubus_ctrl
// PURPOSE
//  Sequencer/arbiter for the internal microcontroller bus, in the FPGA clock domain.
//  Synchronises the uC strobe, decodes the latched address to one of NTGT register targets,
//  runs one handshaked read/write with timeout, and returns data and ready to the uC pin logic.
//  Also owns the attention/interrupt aggregator: sticky pending bits, mask, single uC interrupt.
// PARAMETERS
//  NTGT     8    number of targets; target i owns addresses {i[3:0],12'hxxx}, i < NTGT
//  TIMEOUT  255  cycles in WAIT without t_ack before the access is aborted (1..255)
//  SYNC     2    synchroniser depth on h_strobe (>=2)
// PORTS
//  clk        in   1        system clock
//  reset      in   1        synchronous, active-high
//  h_addr     in   16       address latched by the uC interface
//  h_wdata    in   16       write data from uC pins
//  h_write    in   1        1 = write, 0 = read; stable while h_strobe high
//  h_strobe   in   1        async from uC; rising edge starts one access
//  h_rdata    out  16       read data, valid while h_busy=0 after a read
//  h_busy     out  1        access in progress; uC waits for 0
//  h_irq      out  1        |(pend & mask), registered
//  t_req      out  NTGT     one-hot request to selected target, held until ack/abort
//  t_addr     out  12       offset within target (h_addr[11:0])
//  t_wdata    out  16       write data to target
//  t_write    out  1        direction to target
//  t_rdata    in   16*NTGT  per-target read data, slice i = [16i+15:16i]
//  t_ack      in   NTGT     target i completed; sampled only while t_req[i]=1
//  t_irq      in   NTGT     level attention requests
// BEHAVIOUR
//  Reset: state IDLE; t_req=0, h_busy=0, h_rdata=0, h_irq=0, pend=0, mask=0, err=0.
//  Strobe: SYNC-flop synchroniser + edge detect; rise seen in IDLE -> DECODE next cycle.
//  h_busy=1 from DECODE until DONE; uC samples busy no earlier than SYNC+2 clk after strobe.
//  FSM: IDLE -> DECODE -> {WAIT | LOCAL | DONE(err)} -> DONE -> IDLE.
//   DECODE: latch addr/wdata/write; idx=h_addr[15:12]; idx<NTGT -> WAIT, t_req[idx]=1;
//           idx==4'hF -> LOCAL; else err.nodev=1, h_rdata=16'hFFFF, -> DONE.
//   WAIT: counter from 0; t_ack[idx] -> drop t_req, capture t_rdata slice on read, -> DONE.
//         Count reaches TIMEOUT with no ack -> drop t_req, err.tmo=1, rdata 16'hFFFF, -> DONE.
//         Ack on the TIMEOUT cycle counts as success. Ack from non-selected targets ignored.
//   LOCAL: one cycle; register file at offset [1:0]: 0=PEND (R, W1C), 1=MASK (R/W),
//          2=ERR {14'b0,tmo,nodev} (R, any write clears), 3=reads 0, write ignored.
//          Bits >= NTGT of PEND/MASK read 0.
//   DONE: h_busy=0; h_rdata held; stay until synchronised strobe low, then IDLE.
//  Latency: ack in cycle n -> h_busy low in cycle n+1. LOCAL: busy low 2 cycles after DECODE.
//  Interrupts: each cycle pend <= (pend & ~w1c) | t_irq; set wins over simultaneous clear.
//   h_irq <= |(pend & mask), one cycle after pend/mask update.
//  New strobe edge outside IDLE ignored (no queueing). Reset mid-access drops t_req same edge.
// STRUCTURE
//  ubus_pkg: state encoding, LOCAL offsets (PEND/MASK/ERR), page 4'hF, error fill 16'hFFFF.
//  Sub-module ubus_strobe_sync (SYNC flops + rise/fall pulses); FSM, regs, irq in top.
// TESTING
//  1 Read tgt 2 @16'h2010, ack after 5 clk, rdata=16'hBEEF -> t_req=8'h04, h_rdata=BEEF, busy low.
//  2 Write 16'h3005 data 16'h1234, ack 1 clk -> t_addr=005, t_wdata=1234, t_write=1, one req.
//  3 Read tgt 1, never ack, TIMEOUT=255 -> t_req drops at 255, h_rdata=FFFF, ERR reads 16'h0002.
//  4 Access 16'h9000 (NTGT=8) -> no t_req, h_rdata=FFFF, ERR=16'h0001; write ERR -> 0.
//  5 t_irq[3] pulse, MASK=08 -> h_irq=1; W1C PEND=08 same cycle as t_irq[3] high -> stays set.
//  6 Reset asserted in WAIT -> t_req=0, h_busy=0 next edge; strobe low then new access works.

Source files
------------

// File: rtl/ubus_pkg.sv
// rtl/ubus_pkg.sv - shared types and constants for the microcontroller bus sequencer
package ubus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_WAIT,
        ST_LOCAL,
        ST_DONE
    } ubus_state_e;

    localparam logic [1:0]  LOC_PEND   = 2'd0;
    localparam logic [1:0]  LOC_MASK   = 2'd1;
    localparam logic [1:0]  LOC_ERR    = 2'd2;
    localparam logic [1:0]  LOC_RSVD   = 2'd3;

    localparam logic [3:0]  LOCAL_PAGE = 4'hF;
    localparam logic [15:0] ERR_FILL   = 16'hFFFF;

    function automatic logic [15:0] err_word(input logic tmo, input logic nodev);
        return {14'b0, tmo, nodev};
    endfunction

endpackage

// File: rtl/ubus_strobe_sync.sv
// rtl/ubus_strobe_sync.sv - synchroniser and edge detector for the asynchronous uC strobe
module ubus_strobe_sync #(
    parameter int SYNC = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic strobe_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC-1:0] sync_q;
    logic            prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], strobe_i};
            prev_q <= sync_q[SYNC-1];
        end
    end

    assign level_o = sync_q[SYNC-1];
    assign rise_o  = sync_q[SYNC-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC-1] & prev_q;

endmodule

// File: rtl/ubus_ctrl.sv
// rtl/ubus_ctrl.sv - uC bus sequencer: strobe decode, target handshake with timeout, local regs, irq
module ubus_ctrl
    import ubus_pkg::*;
#(
    parameter int NTGT    = 8,
    parameter int TIMEOUT = 255,
    parameter int SYNC    = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [15:0]          h_addr_i,
    input  logic [15:0]          h_wdata_i,
    input  logic                 h_write_i,
    input  logic                 h_strobe_i,
    output logic [15:0]          h_rdata_o,
    output logic                 h_busy_o,
    output logic                 h_irq_o,
    output logic [NTGT-1:0]      t_req_o,
    output logic [11:0]          t_addr_o,
    output logic [15:0]          t_wdata_o,
    output logic                 t_write_o,
    input  logic [16*NTGT-1:0]   t_rdata_i,
    input  logic [NTGT-1:0]      t_ack_i,
    input  logic [NTGT-1:0]      t_irq_i
);

    logic strobe_lvl;
    logic strobe_rise;
    logic strobe_fall_unused;

    ubus_strobe_sync #(.SYNC(SYNC)) u_strobe_sync (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .strobe_i (h_strobe_i),
        .level_o  (strobe_lvl),
        .rise_o   (strobe_rise),
        .fall_o   (strobe_fall_unused)
    );

    ubus_state_e     state_q;
    logic [7:0]      cnt_q;
    logic [3:0]      idx_q;
    logic [NTGT-1:0] t_req_q;
    logic [11:0]     t_addr_q;
    logic [15:0]     t_wdata_q;
    logic            t_write_q;
    logic [15:0]     h_rdata_q;
    logic            h_busy_q;
    logic            err_tmo_q;
    logic            err_nodev_q;
    logic [NTGT-1:0] pend_q;
    logic [NTGT-1:0] mask_q;
    logic            h_irq_q;

    logic [NTGT-1:0] w1c;
    logic [NTGT-1:0] pend_d;
    logic [15:0]     local_rdata;
    logic            ack_hit;

    // Only the acknowledge of the target we are currently requesting counts.
    assign ack_hit = |(t_ack_i & t_req_q);

    always_comb begin
        w1c = '0;
        if (state_q == ST_LOCAL && t_write_q && t_addr_q[1:0] == LOC_PEND) begin
            w1c = t_wdata_q[NTGT-1:0];
        end
    end

    // A new attention level wins over a write-one-to-clear in the same cycle.
    assign pend_d = (pend_q & ~w1c) | t_irq_i;

    always_comb begin
        local_rdata = '0;
        case (t_addr_q[1:0])
            LOC_PEND: local_rdata = 16'(pend_q);
            LOC_MASK: local_rdata = 16'(mask_q);
            LOC_ERR:  local_rdata = err_word(err_tmo_q, err_nodev_q);
            default:  local_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q  <= '0;
            h_irq_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            h_irq_q <= |(pend_q & mask_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            t_req_q     <= '0;
            t_addr_q    <= '0;
            t_wdata_q   <= '0;
            t_write_q   <= 1'b0;
            h_rdata_q   <= '0;
            h_busy_q    <= 1'b0;
            err_tmo_q   <= 1'b0;
            err_nodev_q <= 1'b0;
            mask_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (strobe_rise) begin
                        state_q  <= ST_DECODE;
                        h_busy_q <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    t_addr_q  <= h_addr_i[11:0];
                    t_wdata_q <= h_wdata_i;
                    t_write_q <= h_write_i;
                    idx_q     <= h_addr_i[15:12];
                    cnt_q     <= '0;
                    if (32'(h_addr_i[15:12]) < NTGT) begin
                        t_req_q <= NTGT'(1) << h_addr_i[15:12];
                        state_q <= ST_WAIT;
                    end else if (h_addr_i[15:12] == LOCAL_PAGE) begin
                        state_q <= ST_LOCAL;
                    end else begin
                        err_nodev_q <= 1'b1;
                        h_rdata_q   <= ERR_FILL;
                        h_busy_q    <= 1'b0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_WAIT: begin
                    if (ack_hit) begin
                        t_req_q  <= '0;
                        h_busy_q <= 1'b0;
                        state_q  <= ST_DONE;
                        if (!t_write_q) begin
                            h_rdata_q <= t_rdata_i[16*idx_q +: 16];
                        end
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        t_req_q   <= '0;
                        err_tmo_q <= 1'b1;
                        h_rdata_q <= ERR_FILL;
                        h_busy_q  <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_LOCAL: begin
                    if (t_write_q) begin
                        case (t_addr_q[1:0])
                            LOC_MASK: mask_q <= t_wdata_q[NTGT-1:0];
                            LOC_ERR: begin
                                err_tmo_q   <= 1'b0;
                                err_nodev_q <= 1'b0;
                            end
                            default: ;
                        endcase
                    end else begin
                        h_rdata_q <= local_rdata;
                    end
                    h_busy_q <= 1'b0;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    if (!strobe_lvl) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign h_rdata_o = h_rdata_q;
    assign h_busy_o  = h_busy_q;
    assign h_irq_o   = h_irq_q;
    assign t_req_o   = t_req_q;
    assign t_addr_o  = t_addr_q;
    assign t_wdata_o = t_wdata_q;
    assign t_write_o = t_write_q;

endmodule

// File: tb/tb_ubus_ctrl.sv
// tb/tb_ubus_ctrl.sv - directed self-checking bench for ubus_ctrl
module tb_ubus_ctrl;

    localparam int NTGT    = 8;
    localparam int TIMEOUT = 255;
    localparam int SYNC    = 2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [15:0]         h_addr = '0;
    logic [15:0]         h_wdata = '0;
    logic                h_write = 1'b0;
    logic                h_strobe = 1'b0;
    logic [15:0]         h_rdata;
    logic                h_busy;
    logic                h_irq;
    logic [NTGT-1:0]     t_req;
    logic [11:0]         t_addr;
    logic [15:0]         t_wdata;
    logic                t_write;
    logic [16*NTGT-1:0]  t_rdata = '0;
    logic [NTGT-1:0]     t_ack = '0;
    logic [NTGT-1:0]     t_irq = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ubus_ctrl #(.NTGT(NTGT), .TIMEOUT(TIMEOUT), .SYNC(SYNC)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .h_addr_i   (h_addr),
        .h_wdata_i  (h_wdata),
        .h_write_i  (h_write),
        .h_strobe_i (h_strobe),
        .h_rdata_o  (h_rdata),
        .h_busy_o   (h_busy),
        .h_irq_o    (h_irq),
        .t_req_o    (t_req),
        .t_addr_o   (t_addr),
        .t_wdata_o  (t_wdata),
        .t_write_o  (t_write),
        .t_rdata_i  (t_rdata),
        .t_ack_i    (t_ack),
        .t_irq_i    (t_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns in the DECODE cycle, i.e. the first cycle busy is seen high.
    task automatic start_access(input logic [15:0] a, input logic [15:0] d, input logic w);
        int n;
        h_addr = a;
        h_wdata = d;
        h_write = w;
        h_strobe = 1'b1;
        n = 0;
        while (h_busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (h_busy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL start_busy addr=%h busy=%b required 1", a, h_busy);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (h_busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        if (h_busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wait_done busy=%b required 0", h_busy);
        end
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (t_req === '0 && n < 20) begin
            tick();
            n++;
        end
        if (t_req === '0) begin
            checks++;
            errors++;
            $display("FAIL wait_req t_req=%h required nonzero", t_req);
        end
    endtask

    task automatic end_access();
        h_strobe = 1'b0;
        repeat (SYNC + 2) tick();
    endtask

    task automatic local_rd(input logic [1:0] off, output logic [15:0] v);
        start_access({14'h3C00, off}, 16'h0000, 1'b0);
        wait_done();
        v = h_rdata;
        end_access();
    endtask

    task automatic local_wr(input logic [1:0] off, input logic [15:0] d);
        start_access({14'h3C00, off}, d, 1'b1);
        wait_done();
        end_access();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if (t_req !== 8'h00 || h_busy !== 1'b0 || h_rdata !== 16'h0000 || h_irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs t_req=%h busy=%b rdata=%h irq=%b required 00 0 0000 0",
                     t_req, h_busy, h_rdata, h_irq);
        end
    endtask

    task automatic test_read_ack();
        t_rdata[16*2 +: 16] = 16'hBEEF;
        t_rdata[16*3 +: 16] = 16'h1111;
        start_access(16'h2010, 16'h0000, 1'b0);
        wait_req();
        checks++;
        if (t_req !== 8'h04 || t_addr !== 12'h010 || t_write !== 1'b0) begin
            errors++;
            $display("FAIL read_req t_req=%h t_addr=%h t_write=%b required 04 010 0", t_req, t_addr, t_write);
        end
        t_ack = 8'h08;
        tick();
        t_ack = 8'h00;
        checks++;
        if (t_req !== 8'h04 || h_busy !== 1'b1) begin
            errors++;
            $display("FAIL foreign_ack t_req=%h busy=%b required 04 1", t_req, h_busy);
        end
        repeat (3) tick();
        t_ack = 8'h04;
        tick();
        t_ack = 8'h00;
        checks++;
        if (h_busy !== 1'b0 || t_req !== 8'h00 || h_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_done busy=%b t_req=%h rdata=%h required 0 00 beef", h_busy, t_req, h_rdata);
        end
        end_access();
    endtask

    task automatic test_write_ack();
        start_access(16'h3005, 16'h1234, 1'b1);
        wait_req();
        checks++;
        if (t_req !== 8'h08 || t_addr !== 12'h005 || t_wdata !== 16'h1234 || t_write !== 1'b1) begin
            errors++;
            $display("FAIL write_req t_req=%h t_addr=%h t_wdata=%h t_write=%b required 08 005 1234 1",
                     t_req, t_addr, t_wdata, t_write);
        end
        t_ack = 8'h08;
        tick();
        t_ack = 8'h00;
        checks++;
        if (h_busy !== 1'b0 || t_req !== 8'h00 || h_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL write_done busy=%b t_req=%h rdata=%h required 0 00 beef", h_busy, t_req, h_rdata);
        end
        end_access();
    endtask

    task automatic test_timeout();
        int n;
        logic [15:0] v;
        start_access(16'h1000, 16'h0000, 1'b0);
        wait_req();
        n = 0;
        while (t_req !== 8'h00 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (n != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_len cycles=%0d required %0d", n, TIMEOUT);
        end
        checks++;
        if (h_busy !== 1'b0 || h_rdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL timeout_fill busy=%b rdata=%h required 0 ffff", h_busy, h_rdata);
        end
        end_access();
        local_rd(2'd2, v);
        checks++;
        if (v !== 16'h0002) begin
            errors++;
            $display("FAIL err_tmo got=%h required 0002", v);
        end
        local_wr(2'd2, 16'h0000);
    endtask

    task automatic test_nodev();
        logic [15:0] v;
        start_access(16'h9000, 16'h0000, 1'b0);
        tick();
        checks++;
        if (t_req !== 8'h00 || h_busy !== 1'b0 || h_rdata !== 16'hFFFF) begin
            errors++;
            $display("FAIL nodev t_req=%h busy=%b rdata=%h required 00 0 ffff", t_req, h_busy, h_rdata);
        end
        end_access();
        local_rd(2'd2, v);
        checks++;
        if (v !== 16'h0001) begin
            errors++;
            $display("FAIL err_nodev got=%h required 0001", v);
        end
        local_wr(2'd2, 16'h5555);
        local_rd(2'd2, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL err_clear got=%h required 0000", v);
        end
    endtask

    task automatic test_local_latency();
        start_access(16'hF001, 16'h0000, 1'b0);
        tick();
        checks++;
        if (h_busy !== 1'b1) begin
            errors++;
            $display("FAIL local_lat1 busy=%b required 1", h_busy);
        end
        tick();
        checks++;
        if (h_busy !== 1'b0 || h_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL local_lat2 busy=%b rdata=%h required 0 0000", h_busy, h_rdata);
        end
        end_access();
    endtask

    task automatic test_irq();
        logic [15:0] v;
        t_irq = 8'h08;
        tick();
        t_irq = 8'h00;
        tick();
        local_wr(2'd1, 16'h0008);
        repeat (2) tick();
        checks++;
        if (h_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_set irq=%b required 1", h_irq);
        end
        local_rd(2'd0, v);
        checks++;
        if (v !== 16'h0008) begin
            errors++;
            $display("FAIL pend_read got=%h required 0008", v);
        end
        local_wr(2'd0, 16'h0008);
        repeat (2) tick();
        local_rd(2'd0, v);
        checks++;
        if (v !== 16'h0000 || h_irq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear pend=%h irq=%b required 0000 0", v, h_irq);
        end
        start_access(16'hF000, 16'h0008, 1'b1);
        tick();
        t_irq = 8'h08;
        tick();
        t_irq = 8'h00;
        wait_done();
        end_access();
        local_rd(2'd0, v);
        checks++;
        if (v !== 16'h0008 || h_irq !== 1'b1) begin
            errors++;
            $display("FAIL set_wins pend=%h irq=%b required 0008 1", v, h_irq);
        end
        local_wr(2'd1, 16'hFFFF);
        local_rd(2'd1, v);
        checks++;
        if (v !== 16'h00FF) begin
            errors++;
            $display("FAIL mask_width got=%h required 00ff", v);
        end
        local_wr(2'd3, 16'hABCD);
        local_rd(2'd3, v);
        checks++;
        if (v !== 16'h0000) begin
            errors++;
            $display("FAIL rsvd_read got=%h required 0000", v);
        end
    endtask

    task automatic test_reset_mid_access();
        start_access(16'h2000, 16'h0000, 1'b0);
        wait_req();
        reset = 1'b1;
        h_strobe = 1'b0;
        tick();
        checks++;
        if (t_req !== 8'h00 || h_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_wait t_req=%h busy=%b required 00 0", t_req, h_busy);
        end
        reset = 1'b0;
        repeat (2) tick();
        t_rdata[16*2 +: 16] = 16'h5A5A;
        start_access(16'h2004, 16'h0000, 1'b0);
        wait_req();
        checks++;
        if (t_req !== 8'h04 || t_addr !== 12'h004) begin
            errors++;
            $display("FAIL post_reset_req t_req=%h t_addr=%h required 04 004", t_req, t_addr);
        end
        t_ack = 8'h04;
        tick();
        t_ack = 8'h00;
        checks++;
        if (h_busy !== 1'b0 || h_rdata !== 16'h5A5A) begin
            errors++;
            $display("FAIL post_reset_read busy=%b rdata=%h required 0 5a5a", h_busy, h_rdata);
        end
        end_access();
    endtask

    initial begin
        test_reset();
        test_read_ack();
        test_write_ack();
        test_timeout();
        test_nodev();
        test_local_latency();
        test_irq();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
